// File: rtl/output_port_allocator.sv
// output_port_allocator: round-robin wormhole output allocator with downstream credit tracking.
// Optional packet counter enabled by defining OUTPUT_PORT_ALLOC_PKT_CNT_EN.
module output_port_allocator #(
    parameter logic [2:0]  PORT_ADDR = 3'd1,
    parameter logic [4:0]  REQ_MASK  = 5'b11101,
    parameter int unsigned CREDITS   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  flit_valid_i,
    input  logic [14:0] nexthop_addr_i,
    input  logic [4:0]  tail_i,
    input  logic        credit_return_i,
`ifdef OUTPUT_PORT_ALLOC_PKT_CNT_EN
    input  logic        pkt_cnt_clr_i,
    output logic [15:0] pkt_cnt_o,
`endif
    output logic [4:0]  grant_o,
    output logic [2:0]  mux_sel_o,
    output logic [4:0]  flit_ack_o,
    output logic        out_valid_o,
    output logic        busy_o,
    output logic [3:0]  credit_cnt_o,
    output logic        credit_err_o
);
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [4:0]  grant_q, grant_d;
    logic [2:0]  mux_sel_q, mux_sel_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  credit_cnt_q, credit_cnt_d;
    logic        credit_err_q, credit_err_d;
    logic [4:0]  req;
    logic [2:0]  win;
    logic [2:0]  idx;
    logic [3:0]  sum;
    logic        fire;
    logic        tail_fire;

    // Per-input requests and the round-robin winner (descending scan so the first hit from rr_ptr wins)
    always_comb begin
        req = '0;
        win = '0;
        idx = '0;
        sum = '0;
        for (int k = 0; k < 5; k++)
            req[k] = flit_valid_i[k] & (nexthop_addr_i[3*k +: 3] == PORT_ADDR) & REQ_MASK[k];
        for (int i = 4; i >= 0; i--) begin
            sum = {1'b0, rr_ptr_q} + 4'(i);
            idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (req[idx]) win = idx;
        end
    end

    // Next-state logic for arbitration, packet lock and credit accounting
    always_comb begin
        fire         = (state_q == LOCKED) & flit_valid_i[mux_sel_q] & (credit_cnt_q != 4'd0);
        tail_fire    = fire & tail_i[mux_sel_q];
        state_d      = state_q;
        grant_d      = grant_q;
        mux_sel_d    = mux_sel_q;
        rr_ptr_d     = rr_ptr_q;
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q;
        if (state_q == IDLE && |req) begin
            state_d   = LOCKED;
            grant_d   = 5'b00001 << win;
            mux_sel_d = win;
        end
        if (tail_fire) begin
            state_d   = IDLE;
            grant_d   = '0;
            mux_sel_d = '0;
            rr_ptr_d  = (mux_sel_q == 3'd4) ? 3'd0 : mux_sel_q + 3'd1;
        end
        if (credit_return_i && !fire) begin
            if (credit_cnt_q == CRED_MAX) credit_err_d = 1'b1;
            else credit_cnt_d = credit_cnt_q + 4'd1;
        end else if (fire && !credit_return_i) begin
            credit_cnt_d = credit_cnt_q - 4'd1;
        end
    end

    // State and credit registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            mux_sel_q    <= '0;
            rr_ptr_q     <= '0;
            credit_cnt_q <= CRED_MAX;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            mux_sel_q    <= mux_sel_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
        end
    end

`ifdef OUTPUT_PORT_ALLOC_PKT_CNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    // Completed-packet counter; clear wins over increment
    always_comb begin
        pkt_cnt_d = pkt_cnt_clr_i ? 16'd0 : (tail_fire ? pkt_cnt_q + 16'd1 : pkt_cnt_q);
    end

    // Packet counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pkt_cnt_q <= '0;
        else pkt_cnt_q <= pkt_cnt_d;
    end

    assign pkt_cnt_o = pkt_cnt_q;
`endif

    assign grant_o      = grant_q;
    assign mux_sel_o    = mux_sel_q;
    assign busy_o       = (state_q == LOCKED);
    assign out_valid_o  = fire;
    assign flit_ack_o   = grant_q & {5{fire}};
    assign credit_cnt_o = credit_cnt_q;
    assign credit_err_o = credit_err_q;
endmodule

// File: tb/tb_output_port_allocator.sv
// tb_output_port_allocator: randomized + directed bench against a behavioural allocator model.
module tb_output_port_allocator;
    localparam int CREDITS = 4;
    localparam logic [4:0] MASK = 5'b11101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  flit_valid_i = '0;
    logic [14:0] nexthop_addr_i = '0;
    logic [4:0]  tail_i = '0;
    logic        credit_return_i = 1'b0;
    logic [4:0]  grant_o;
    logic [2:0]  mux_sel_o;
    logic [4:0]  flit_ack_o;
    logic        out_valid_o;
    logic        busy_o;
    logic [3:0]  credit_cnt_o;
    logic        credit_err_o;
`ifdef OUTPUT_PORT_ALLOC_PKT_CNT_EN
    logic        pkt_cnt_clr_i = 1'b0;
    logic [15:0] pkt_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    // behavioural model state
    bit m_locked;
    int m_g, m_rr, m_cred, m_fire_idx, m_new_g;
    bit m_err, m_fire;
    int dut_acks;
    int sent[5];
    int order[$];

    output_port_allocator #(.PORT_ADDR(3'd1), .REQ_MASK(MASK), .CREDITS(CREDITS)) dut (
        .clk(clk), .reset(reset),
        .flit_valid_i(flit_valid_i), .nexthop_addr_i(nexthop_addr_i),
        .tail_i(tail_i), .credit_return_i(credit_return_i),
`ifdef OUTPUT_PORT_ALLOC_PKT_CNT_EN
        .pkt_cnt_clr_i(pkt_cnt_clr_i), .pkt_cnt_o(pkt_cnt_o),
`endif
        .grant_o(grant_o), .mux_sel_o(mux_sel_o), .flit_ack_o(flit_ack_o),
        .out_valid_o(out_valid_o), .busy_o(busy_o),
        .credit_cnt_o(credit_cnt_o), .credit_err_o(credit_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_g = 0; m_rr = 0; m_cred = CREDITS; m_err = 0;
    endtask

    function automatic bit m_req(input int k);
        return flit_valid_i[k] && nexthop_addr_i[3*k +: 3] == 3'd1 && MASK[k];
    endfunction

    task automatic model_check();
        m_fire = m_locked && flit_valid_i[m_g] && m_cred > 0;
        m_fire_idx = m_fire ? m_g : -1;
        chk("grant", int'(grant_o), m_locked ? (1 << m_g) : 0);
        chk("mux_sel", int'(mux_sel_o), m_locked ? m_g : 0);
        chk("busy", int'(busy_o), int'(m_locked));
        chk("out_valid", int'(out_valid_o), int'(m_fire));
        chk("flit_ack", int'(flit_ack_o), m_fire ? (1 << m_g) : 0);
        chk("credit_cnt", int'(credit_cnt_o), m_cred);
        chk("credit_err", int'(credit_err_o), int'(m_err));
        if (flit_ack_o != 5'd0) dut_acks++;
    endtask

    task automatic model_update();
        m_new_g = -1;
        if (!m_locked) begin
            for (int j = 0; j < 5; j++)
                if (m_new_g < 0 && m_req((m_rr + j) % 5)) m_new_g = (m_rr + j) % 5;
            if (m_new_g >= 0) begin m_locked = 1; m_g = m_new_g; end
        end else if (m_fire && tail_i[m_g]) begin
            m_locked = 0;
            m_rr = (m_g + 1) % 5;
        end
        if (credit_return_i && !m_fire) begin
            if (m_cred == CREDITS) m_err = 1;
            else m_cred++;
        end else if (m_fire && !credit_return_i) m_cred--;
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        flit_valid_i = '0; tail_i = '0; credit_return_i = 1'b0; nexthop_addr_i = '0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        do_reset();
        chk("rst_grant", int'(grant_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_cnt", int'(credit_cnt_o), 4);
        chk("rst_err", int'(credit_err_o), 0);

        // single-flit packet from n
        flit_valid_i = 5'b00001; nexthop_addr_i = 15'd1; tail_i = 5'b00001;
        step();
        chk("n_grant", int'(grant_o), 1);
        chk("n_sel", int'(mux_sel_o), 0);
        chk("n_ack", int'(flit_ack_o), 1);
        chk("n_valid", int'(out_valid_o), 1);
        step();
        flit_valid_i = '0; tail_i = '0;
        chk("n_idle", int'(busy_o), 0);

        // w, e, l contend with 3-flit packets
        flit_valid_i = 5'b11100;
        nexthop_addr_i = {3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
        for (int k = 0; k < 5; k++) sent[k] = 0;
        for (int c = 0; c < 200 && order.size() < 4; c++) begin
            for (int k = 0; k < 5; k++) tail_i[k] = (sent[k] % 3 == 2);
            credit_return_i = (m_cred < CREDITS);
            step();
            if (m_fire_idx >= 0) sent[m_fire_idx]++;
            if (m_new_g >= 0) order.push_back(m_new_g);
        end
        credit_return_i = 1'b0;
        chk("rr_count", order.size(), 4);
        if (order.size() == 4) begin
            chk("rr_0", order[0], 2);
            chk("rr_1", order[1], 3);
            chk("rr_2", order[2], 4);
            chk("rr_3", order[3], 2);
        end

        // credit stall on e
        do_reset();
        flit_valid_i = 5'b01000; nexthop_addr_i = 15'd1 << 9; tail_i = '0;
        dut_acks = 0;
        repeat (10) step();
        chk("stall_acks", dut_acks, 4);
        chk("stall_cnt", int'(credit_cnt_o), 0);
        chk("stall_grant", int'(grant_o), 5'b01000);
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;
        repeat (5) step();
        chk("stall_one_more", dut_acks, 5);
        chk("stall_grant_held", int'(grant_o), 5'b01000);

        // masked s and wrong next-hop on n
        do_reset();
        flit_valid_i = 5'b00010; nexthop_addr_i = 15'd1 << 3;
        repeat (4) step();
        chk("s_masked", int'(grant_o), 0);
        flit_valid_i = 5'b00001; nexthop_addr_i = 15'd3;
        repeat (4) step();
        chk("n_wrong_hop", int'(busy_o), 0);

        // async reset mid-packet while l is locked
        do_reset();
        flit_valid_i = 5'b00100; nexthop_addr_i = 15'd1 << 6; tail_i = 5'b00100;
        step(); step();
        flit_valid_i = '0; tail_i = '0;
        step();
        flit_valid_i = 5'b10000; nexthop_addr_i = 15'd1 << 12;
        step(); step();
        chk("l_locked", int'(grant_o), 5'b10000);
        #2 reset = 1'b1;
        #1;
        chk("arst_grant", int'(grant_o), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_cnt", int'(credit_cnt_o), 4);
        chk("arst_valid", int'(out_valid_o), 0);
        @(negedge clk);
        reset = 1'b0; flit_valid_i = '0;
        model_reset();
        @(posedge clk);
        #1;
        flit_valid_i = 5'b01100; nexthop_addr_i = (15'd1 << 6) | (15'd1 << 9);
        step();
        chk("arst_rr0", int'(grant_o), 5'b00100);

        // fire and return in the same cycle
        do_reset();
        flit_valid_i = 5'b00001; nexthop_addr_i = 15'd1; tail_i = '0;
        step(); step();
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;
        chk("fire_ret_cnt", int'(credit_cnt_o), 3);

        // credit return at full
        do_reset();
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;
        chk("err_cnt", int'(credit_cnt_o), 4);
        chk("err_set", int'(credit_err_o), 1);
        repeat (3) step();
        chk("err_sticky", int'(credit_err_o), 1);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            flit_valid_i = 5'($urandom);
            for (int k = 0; k < 5; k++)
                nexthop_addr_i[3*k +: 3] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'd1;
            for (int k = 0; k < 5; k++) tail_i[k] = ($urandom_range(0, 3) == 0);
            credit_return_i = (m_cred < CREDITS) && ($urandom_range(0, 1) == 1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
- Sequential output-port allocator for one NOC router output (N, S, W, E or L), driven by per-input head-flit next-hop addresses.
- Picks one requesting input by rotating round-robin and locks that grant for the whole wormhole packet, until the tail flit is sent.
- Drives the 5:1 crossbar mux select and tracks downstream buffer credits.
- One instance sits beside each output port's crossbar mux.

Parameters:
- PORT_ADDR, 3'd1, next-hop code that this output port serves (n=0, s=1, w=2, e=3, l=4).
- REQ_MASK, 5'b11101, per-input enable in bit order {l,e,w,s,n}; a cleared bit (no U-turn) never requests.
- CREDITS, 4, downstream buffer depth in flits; allowed range 1..15.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- flit_valid_i  input  5  per-input flit present, bit order {l,e,w,s,n}
- nexthop_addr_i  input  15  per-input 3-bit next-hop code; input k uses bits [3k+2:3k]; meaningful on head flits
- tail_i  input  5  per-input flag: the current flit is the tail
- credit_return_i  input  1  downstream freed one buffer slot
- grant_o  output  5  one-hot locked input, 0 when idle
- mux_sel_o  output  3  crossbar select, index of the granted input (0..4)
- flit_ack_o  output  5  one-hot: granted input's flit consumed this cycle
- out_valid_o  output  1  flit driven to downstream this cycle
- busy_o  output  1  state is LOCKED
- credit_cnt_o  output  4  available credits
- credit_err_o  output  1  sticky: credit returned while counter full

Behaviour:
- Request: req[k] = flit_valid_i[k] & (nexthop_addr_i[k] == PORT_ADDR) & REQ_MASK[k]. Combinational, evaluated only in IDLE.
- State machine states: IDLE, LOCKED.
- IDLE, any req:
  - Winner = first set req index scanning rr_ptr, rr_ptr+1, ... mod 5.
  - On the next edge: grant_o <= onehot(winner), mux_sel_o <= winner, state <= LOCKED.
  - Request-to-grant latency is 1 cycle.
- IDLE, no req: all outputs hold 0 except credit_cnt_o and credit_err_o.
- LOCKED, fire condition: fire = flit_valid_i[g] & (credit_cnt != 0).
  - out_valid_o = fire, combinational.
  - flit_ack_o = grant_o & {5{fire}}.
  - Next-hop is not re-checked; body flits carry no address.
- LOCKED, fire & tail_i[g]:
  - Next edge: state <= IDLE, grant_o <= 0, rr_ptr <= (g == 4) ? 0 : g+1.
  - A single-flit packet (head = tail) follows the same path.
  - One mandatory idle bubble cycle between packets.
- LOCKED, credit_cnt == 0: hold the grant, no ack. The stall is unbounded.
- Credit counter:
  - Decrements on fire and increments on credit_return_i.
  - Both in the same cycle: unchanged.
  - Return at CREDITS: counter saturates, credit_err_o <= 1 until reset.
- Grant changes only in IDLE; rr_ptr changes only on tail fire.
- flit_valid_i deasserting mid-packet: remain LOCKED, ack 0.
- Reset (asynchronous, any state including mid-packet):
  - state = IDLE, grant_o = 0, mux_sel_o = 0, flit_ack_o = 0, out_valid_o = 0, busy_o = 0.
  - rr_ptr = 0, credit_cnt_o = CREDITS, credit_err_o = 0.

Optional Feature:
- Macro: OUTPUT_PORT_ALLOC_PKT_CNT_EN.
- Defined:
  - Adds output pkt_cnt_o [15:0], reset 0.
  - Increments on each tail fire and wraps 16'hFFFF -> 0.
  - Adds input pkt_cnt_clr_i; clear has priority over increment.
- Undefined: neither port exists and the counter logic is absent.

Test Plan:
- After reset, n (code 1, single-flit, tail=1) requests → grant_o = 5'b00001 and mux_sel_o = 0 at cycle 1; out_valid_o and flit_ack_o = 5'b00001 at cycle 1; idle at cycle 2; rr_ptr = 1.
- w, e, l all request code 1 continuously, each packet 3 flits, credits ample → grant order w, e, l, w (indices 2, 3, 4, 2); rr_ptr wraps 4 → 0 and skips masked s.
- e locked, CREDITS=4, no credit_return_i, 6-flit packet → 4 acks, then stall with credit_cnt_o = 0 and grant held; one credit_return_i → exactly one more ack.
- s (bit 1) valid with code 1 and REQ_MASK=5'b11101 → never granted; n requesting code 3 → no grant.
- Reset asserted mid-packet while l is locked → grant_o = 0, busy_o = 0 and credit_cnt_o = 4 immediately, without waiting for a clock edge; next request arbitrates from rr_ptr = 0.
- credit_return_i pulsed while credit_cnt_o = 4 → counter stays 4 and credit_err_o = 1 until reset; fire and return in the same cycle → counter unchanged.
